// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//
// Instruction-fetch stage and IF/ID pipeline register of the five-stage RV32I
// pipeline. This module holds the fetch PC and drives the instruction-memory
// address. It also computes the sequential PC and captures the fetched word
// into the IF/ID register, which the decode stage reads.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, the fetch_cnt and stall_cnt performance counters and their
//   ports are present. When undefined, the counters and ports do not exist.
//
// Parameters:
//   XLEN       datapath / PC width
//   RESET_PC   PC loaded on reset
//   NOP_INSTR  bubble word (addi x0,x0,0) placed in IF/ID on reset and flush
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   stall_f     hold the fetch PC
//   stall_d     hold the IF/ID register
//   flush_d     replace the IF/ID contents with a bubble
//   pcsrc_e     taken branch/jump in EX; redirect the PC
//   pctarget_e  redirect target (bits [1:0] are ignored)
//   imem_addr   instruction-memory address (always equals pc_f)
//   imem_rdata  instruction word, combinational read of imem_addr
//   pc_f        current fetch PC
//   instr_d     IF/ID instruction
//   op_d        instr_d[6:0], for the main decoder
//   pc_d        PC of instr_d
//   pcplus4_d   pc_d + 4
//   valid_d     instr_d is a real fetched word, not a bubble
//   fetch_cnt   words loaded into IF/ID (FETCH_PERF_CNT_EN only)
//   stall_cnt   cycles IF/ID was held by stall_d (FETCH_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module if_id_stage #(
    parameter int unsigned        XLEN      = 32,
    parameter logic [XLEN-1:0]    RESET_PC  = '0,
    parameter logic [31:0]        NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pcsrc_e,
    input  logic [XLEN-1:0] pctarget_e,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc_f,
    output logic [31:0]     instr_d,
    output logic [6:0]      op_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pcplus4_d,
    output logic            valid_d
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    logic [XLEN-1:0] pc_f_q, pc_f_d;
    logic [XLEN-1:0] pc_plus4_f;
    logic [31:0]     instr_d_q, instr_d_d;
    logic [XLEN-1:0] pc_d_q, pc_d_d;
    logic [XLEN-1:0] pcplus4_d_q, pcplus4_d_d;
    logic            valid_d_q, valid_d_d;
    logic            load_d;

    // Redirect targets are always word aligned, so the two low target bits
    // are dropped on purpose. This XOR only marks them as deliberately
    // unused.
    logic            target_lsb_unused;
    assign target_lsb_unused = ^pctarget_e[1:0];

    // The addition wraps modulo 2^XLEN, so 0xFFFF_FFFC + 4 becomes 0.
    assign pc_plus4_f = pc_f_q + XLEN'(4);

    // A redirect from EX beats stall_f. If it did not, a taken branch that
    // coincides with a load-use stall would be lost.
    always_comb begin
        pc_f_d = pc_f_q;
        if (pcsrc_e) begin
            pc_f_d = {pctarget_e[XLEN-1:2], 2'b00};
        end else if (!stall_f) begin
            pc_f_d = pc_plus4_f;
        end
    end

    // A flush beats stall_d, so a squashed wrong-path word never survives in
    // IF/ID. The load condition is shared with the fetch counter.
    assign load_d = !flush_d && !stall_d;

    always_comb begin
        instr_d_d   = instr_d_q;
        pc_d_d      = pc_d_q;
        pcplus4_d_d = pcplus4_d_q;
        valid_d_d   = valid_d_q;
        if (flush_d) begin
            instr_d_d   = NOP_INSTR;
            pc_d_d      = '0;
            pcplus4_d_d = '0;
            valid_d_d   = 1'b0;
        end else if (load_d) begin
            instr_d_d   = imem_rdata;
            pc_d_d      = pc_f_q;
            pcplus4_d_d = pc_plus4_f;
            valid_d_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q      <= RESET_PC;
            instr_d_q   <= NOP_INSTR;
            pc_d_q      <= '0;
            pcplus4_d_q <= '0;
            valid_d_q   <= 1'b0;
        end else begin
            pc_f_q      <= pc_f_d;
            instr_d_q   <= instr_d_d;
            pc_d_q      <= pc_d_d;
            pcplus4_d_q <= pcplus4_d_d;
            valid_d_q   <= valid_d_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Both counters saturate at all-ones instead of wrapping. A flush takes
    // precedence, so a flushed cycle is counted as neither a fetch nor a
    // stall.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (load_d && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (stall_d && !flush_d && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

    assign imem_addr = pc_f_q;
    assign pc_f      = pc_f_q;
    assign instr_d   = instr_d_q;
    assign op_d      = instr_d_q[6:0];
    assign pc_d      = pc_d_q;
    assign pcplus4_d = pcplus4_d_q;
    assign valid_d   = valid_d_q;

endmodule

// File: tb/tb_if_id_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage
//
// Self-checking bench for if_id_stage with RESET_PC = 0x100. A small
// combinational instruction memory answers imem_addr. A table of per-cycle
// input vectors and the expected post-edge state is applied in a loop.
// Hand-written sequences then cover reset that arrives mid-redirect.
// The performance counters are checked when FETCH_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        pcsrc_e;
    logic [31:0] pctarget_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [6:0]  op_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] exp_fetch_cnt;
    logic [31:0] exp_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    if_id_stage #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0100),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .pcsrc_e    (pcsrc_e),
        .pctarget_e (pctarget_e),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .pc_f       (pc_f),
        .instr_d    (instr_d),
        .op_d       (op_d),
        .pc_d       (pc_d),
        .pcplus4_d  (pcplus4_d),
        .valid_d    (valid_d)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents used by the bench
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: imem_word = 32'h0050_0093;
            32'h0000_0104: imem_word = 32'h00A0_0113;
            32'h0000_0108: imem_word = 32'h00B0_0193;
            32'h0000_0200: imem_word = 32'h00C0_0213;
            32'h0000_0300: imem_word = 32'h0040_0293;
            32'hFFFF_FFFC: imem_word = 32'h0010_0313;
            default:       imem_word = 32'h0000_0033;
        endcase
    endfunction

    always_comb imem_rdata = imem_word(imem_addr);

    typedef struct {
        logic        rst;
        logic        sf;
        logic        sd;
        logic        fl;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] e_pc_f;
        logic [31:0] e_instr;
        logic [31:0] e_pc_d;
        logic [31:0] e_p4;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic sf, input logic sd,
                                input logic fl, input logic br, input logic [31:0] tgt,
                                input logic [31:0] e_pc_f, input logic [31:0] e_instr,
                                input logic [31:0] e_pc_d, input logic [31:0] e_p4,
                                input logic e_valid);
        vec_t v;
        v.rst = rst; v.sf = sf; v.sd = sd; v.fl = fl; v.br = br; v.tgt = tgt;
        v.e_pc_f = e_pc_f; v.e_instr = e_instr; v.e_pc_d = e_pc_d;
        v.e_p4 = e_p4; v.e_valid = e_valid;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive inputs on the falling edge and check the state just after the
    // following rising edge. The counter model is updated alongside.
    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        reset      = v.rst;
        stall_f    = v.sf;
        stall_d    = v.sd;
        flush_d    = v.fl;
        pcsrc_e    = v.br;
        pctarget_e = v.tgt;
        @(posedge clk);
`ifdef FETCH_PERF_CNT_EN
        if (v.rst) begin
            exp_fetch_cnt = 0;
            exp_stall_cnt = 0;
        end else begin
            if (!v.fl && !v.sd) exp_fetch_cnt++;
            if (!v.fl && v.sd)  exp_stall_cnt++;
        end
`endif
        #1;
        checkOutput({tag, " pc_f"},      pc_f,             v.e_pc_f);
        checkOutput({tag, " imem_addr"}, imem_addr,        v.e_pc_f);
        checkOutput({tag, " instr_d"},   instr_d,          v.e_instr);
        checkOutput({tag, " op_d"},      {25'd0, op_d},    {25'd0, v.e_instr[6:0]});
        checkOutput({tag, " pc_d"},      pc_d,             v.e_pc_d);
        checkOutput({tag, " pcplus4_d"}, pcplus4_d,        v.e_p4);
        checkOutput({tag, " valid_d"},   {31'd0, valid_d}, {31'd0, v.e_valid});
`ifdef FETCH_PERF_CNT_EN
        checkOutput({tag, " fetch_cnt"}, fetch_cnt, exp_fetch_cnt);
        checkOutput({tag, " stall_cnt"}, stall_cnt, exp_stall_cnt);
`endif
    endtask

    initial begin
        reset = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pcsrc_e = 1'b0; pctarget_e = '0;
`ifdef FETCH_PERF_CNT_EN
        exp_fetch_cnt = 0;
        exp_stall_cnt = 0;
`endif

        //          rst sf sd fl br target         pc_f           instr          pc_d           pc+4           v
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         32'h0000_0100, NOP,           32'h0,         32'h0,         0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         32'h0000_0100, NOP,           32'h0,         32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0000_0104, 32'h0050_0093, 32'h0000_0100, 32'h0000_0104, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0000_0108, 32'h00A0_0113, 32'h0000_0104, 32'h0000_0108, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         32'h0000_0108, 32'h00A0_0113, 32'h0000_0104, 32'h0000_0108, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         32'h0000_0108, 32'h00A0_0113, 32'h0000_0104, 32'h0000_0108, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         32'h0000_0108, 32'h00A0_0113, 32'h0000_0104, 32'h0000_0108, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0000_010C, 32'h00B0_0193, 32'h0000_0108, 32'h0000_010C, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0000_0203, 32'h0000_0200, NOP,           32'h0,         32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0000_0204, 32'h00C0_0213, 32'h0000_0200, 32'h0000_0204, 1));
        vecs.push_back(mk(0, 1, 1, 0, 1, 32'h0000_0300, 32'h0000_0300, 32'h00C0_0213, 32'h0000_0200, 32'h0000_0204, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 32'h0,         32'h0000_0300, NOP,           32'h0,         32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0000_0304, 32'h0040_0293, 32'h0000_0300, 32'h0000_0304, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, NOP,           32'h0,         32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0000_0000, 32'h0010_0313, 32'hFFFF_FFFC, 32'h0000_0000, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         32'h0000_0000, 32'h0010_0313, 32'hFFFF_FFFC, 32'h0000_0000, 1));
        vecs.push_back(mk(1, 1, 1, 0, 0, 32'h0,         32'h0000_0100, NOP,           32'h0,         32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0000_0104, 32'h0050_0093, 32'h0000_0100, 32'h0000_0104, 1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
`ifdef FETCH_PERF_CNT_EN
            if (i == 6) checkOutput("stall_cnt after 3-cycle stall", stall_cnt, 32'd3);
`endif
        end

        // Reset arriving during a redirect and flush wins over both
        applyStimulus(mk(0, 0, 0, 0, 0, 32'h0, 32'h0000_0108, 32'h00A0_0113,
                         32'h0000_0104, 32'h0000_0108, 1), "seq_pre");
        applyStimulus(mk(1, 1, 0, 1, 1, 32'h0000_0200, 32'h0000_0100, NOP,
                         32'h0, 32'h0, 0), "seq_rst_redirect");
        applyStimulus(mk(0, 0, 0, 0, 0, 32'h0, 32'h0000_0104, 32'h0050_0093,
                         32'h0000_0100, 32'h0000_0104, 1), "seq_post");

        // stall_f alone holds the PC while IF/ID keeps loading the same word
        applyStimulus(mk(0, 1, 0, 0, 0, 32'h0, 32'h0000_0104, 32'h00A0_0113,
                         32'h0000_0104, 32'h0000_0108, 1), "seq_sf_only");
        applyStimulus(mk(0, 1, 0, 0, 0, 32'h0, 32'h0000_0104, 32'h00A0_0113,
                         32'h0000_0104, 32'h0000_0108, 1), "seq_sf_only2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage RV32I pipeline. Holds the PC, drives the instruction-memory address, computes the sequential PC and captures the fetched word into the IF/ID register. The decode stage, including the main decoder, reads its opcode from this register. Stall and flush inputs come from the hazard unit; redirect inputs come from the execute stage.

## Interface
- XLEN, 32: datapath and PC width.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: bubble word (addi x0,x0,0) inserted on flush and reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- stall_f  in  1  hold the PC.
- stall_d  in  1  hold the IF/ID register.
- flush_d  in  1  replace IF/ID contents with a bubble.
- pcsrc_e  in  1  taken branch or jump in EX; redirect the PC.
- pctarget_e  in  XLEN  redirect target.
- imem_addr  out  XLEN  instruction-memory address (equals pc_f).
- imem_rdata  in  32  instruction word; combinational read of imem_addr.
- pc_f  out  XLEN  current fetch PC.
- instr_d  out  32  IF/ID instruction.
- op_d  out  7  instr_d[6:0], for the main decoder.
- pc_d  out  XLEN  PC of instr_d.
- pcplus4_d  out  XLEN  pc_d + 4.
- valid_d  out  1  instr_d is a real fetched instruction, not a bubble.
- fetch_cnt  out  32  only with FETCH_PERF_CNT_EN.
- stall_cnt  out  32  only with FETCH_PERF_CNT_EN.

## Operation
- **Reset values** (reset high at a rising edge):
  - pc_f = RESET_PC
  - instr_d = NOP_INSTR, valid_d = 0
  - pc_d = 0, pcplus4_d = 0
  - counters = 0
  - Reset overrides every other input, including in the middle of a stall or redirect.
- **PC update**, in priority order:
  - reset
  - pcsrc_e: pc_f <= {pctarget_e[XLEN-1:2], 2'b00}. Target bits [1:0] are ignored.
  - stall_f: hold.
  - otherwise: pc_f <= pc_f + 4.
  - Redirect beats stall_f.
- **IF/ID update**, in priority order:
  - reset
  - flush_d: instr_d <= NOP_INSTR, valid_d <= 0, pc_d <= 0, pcplus4_d <= 0.
  - stall_d: hold all fields.
  - otherwise: instr_d <= imem_rdata, pc_d <= pc_f, pcplus4_d <= pc_f + 4, valid_d <= 1.
  - Flush beats stall_d.
- **Arithmetic:** all PC additions are modulo 2^XLEN. 0xFFFF_FFFC + 4 wraps to 0 with no flag.
- **Combinational outputs:** imem_addr and op_d are pure wires. No other outputs are combinational.
- **Simultaneous pcsrc_e and flush_d** (the normal taken-branch case): the wrong-path word is discarded and the target is fetched next cycle.

## Timing
- Fetch-to-decode latency is 1 cycle. A word presented at imem_addr = A in cycle n appears on instr_d with pc_d = A in cycle n+1.
- Redirect penalty: pcsrc_e asserted in cycle n gives pc_f = target in cycle n+1 and instr_d = imem[target] in cycle n+2.
- A stall asserted for k cycles holds pc_f and instr_d for k cycles. The next sequential word is then loaded with no loss and no duplication, provided stall_f and stall_d are asserted together.
- No handshake with memory: imem_rdata must be valid in the same cycle as imem_addr.

## Configuration
- **FETCH_PERF_CNT_EN defined:** fetch_cnt and stall_cnt ports exist.
  - fetch_cnt increments on every edge where IF/ID loads a new word (no reset, no flush_d, no stall_d).
  - stall_cnt increments on every edge with stall_d = 1 and flush_d = 0.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- **FETCH_PERF_CNT_EN undefined:** the counter ports and registers are absent. All other behaviour is identical.

## Test plan
- **Reset:** hold reset 2 cycles with RESET_PC = 0x100 -> pc_f = 0x100, instr_d = 0x00000013, valid_d = 0, op_d = 7'b0010011.
- **Sequential fetch:** imem returns 0x00500093 at 0x100 and 0x00A00113 at 0x104 -> instr_d/pc_d = 0x00500093/0x100, then 0x00A00113/0x104. pcplus4_d = 0x104, then 0x108.
- **Stall:** stall_f = stall_d = 1 for 3 cycles at pc_f = 0x108 -> pc_f stays 0x108 and instr_d stays at word 0x104. After release, pc_d = 0x108. With FETCH_PERF_CNT_EN, stall_cnt = 3.
- **Redirect and flush:** pcsrc_e = 1, flush_d = 1, pctarget_e = 0x203 -> next cycle pc_f = 0x200, valid_d = 0, instr_d = NOP. One cycle later pc_d = 0x200, valid_d = 1.
- **Priority:** pcsrc_e with stall_f -> PC redirects. flush_d with stall_d -> bubble.
- **Wrap and mid-operation reset:**
  - pc_f = 0xFFFF_FFFC with no stall -> pc_f = 0 next cycle.
  - reset during a stall -> all reset values next cycle.
